// File: rtl/ofm_drain.sv
// ofm_drain: read side of the FC layer controller.
//
// Each set_output pulse captures one tile of TILING_SIZE results into a
// 2-entry tile FIFO. The tiles are then sent out one element per transfer on a
// valid/ready stream, together with the neuron index and a last-of-layer flag.
// A tile that arrives while both entries are occupied, and no pop happens in
// that cycle, is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   clear             synchronous soft clear, same effect as rst
//   set_output        one-cycle pulse: psum_in holds a complete tile
//   psum_in           tile, element i at [i*DATA_W +: DATA_W]
//   ofm_data          current element
//   ofm_valid         ofm_data/ofm_index/ofm_last are valid
//   ofm_ready         downstream accepts when ofm_valid & ofm_ready
//   ofm_index         neuron index = tile_cnt*TILING_SIZE + elem_cnt
//   ofm_last          high with element KERNEL_SIZE-1
//   busy              a tile is buffered or being sent
//   done              one-cycle pulse after the last element is accepted
//   overflow          sticky: a tile was dropped
//
// Build option: define OFM_RELU_EN to clamp negative elements to zero at the
// output. This adds no latency.
module ofm_drain #(
    parameter int TILING_SIZE = 8,
    parameter int KERNEL_SIZE = 4096,
    parameter int DATA_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          set_output,
    input  logic [TILING_SIZE*DATA_W-1:0] psum_in,
    output logic [DATA_W-1:0]             ofm_data,
    output logic                          ofm_valid,
    input  logic                          ofm_ready,
    output logic [15:0]                   ofm_index,
    output logic                          ofm_last,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);
    localparam int NUM_TILES = KERNEL_SIZE / TILING_SIZE;
    localparam int EW        = $clog2(TILING_SIZE);
    localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int TILE_W    = TILING_SIZE * DATA_W;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t            state_reg, state_next;
    logic [TILE_W-1:0] tile_mem [2];
    logic              wr_ptr_reg, wr_ptr_next;
    logic              rd_ptr_reg, rd_ptr_next;
    logic [1:0]        count_reg, count_next;
    logic [EW-1:0]     elem_cnt_reg, elem_cnt_next;
    logic [TW-1:0]     tile_cnt_reg, tile_cnt_next;

    logic              accept, last_elem, last_tile, pop, capture, sending;
    logic [TILE_W-1:0] head_tile;
    logic [DATA_W-1:0] head_elems [TILING_SIZE];
    logic [DATA_W-1:0] elem_raw, elem_out;

    // ofm_valid is only ever high in SEND, so this is a transfer of the head tile.
    assign accept    = ofm_valid & ofm_ready;
    assign last_elem = (elem_cnt_reg == EW'(TILING_SIZE - 1));
    assign last_tile = (tile_cnt_reg == TW'(NUM_TILES - 1));
    assign pop       = accept & last_elem;
    // A full FIFO still takes the new tile when the head leaves in the same cycle.
    assign capture   = set_output & ((count_reg != 2'd2) | pop);

    always_comb begin
        count_next    = count_reg + {1'b0, capture} - {1'b0, pop};
        wr_ptr_next   = wr_ptr_reg ^ capture;
        rd_ptr_next   = rd_ptr_reg ^ pop;
        state_next    = state_reg;
        elem_cnt_next = elem_cnt_reg;
        tile_cnt_next = tile_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if ((count_reg != 2'd0) || capture) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (last_elem) begin
                        elem_cnt_next = '0;
                        if (last_tile) begin
                            tile_cnt_next = '0;
                            state_next    = DONE;
                        end else begin
                            tile_cnt_next = tile_cnt_reg + TW'(1);
                            // count_next includes a same-cycle capture, so a
                            // tile arriving now is sent without a bubble.
                            state_next    = (count_next != 2'd0) ? SEND : IDLE;
                        end
                    end else begin
                        elem_cnt_next = elem_cnt_reg + EW'(1);
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-cycle head. If the head for next
    // cycle is the slot being written right now, take the element straight
    // from psum_in so a fresh tile appears one cycle after set_output.
    assign head_tile = (capture && (wr_ptr_reg == rd_ptr_next)) ? psum_in
                                                                : tile_mem[rd_ptr_next];

    generate
        for (genvar gi = 0; gi < TILING_SIZE; gi++) begin : g_elems
            assign head_elems[gi] = head_tile[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign elem_raw = head_elems[elem_cnt_next];
    assign sending  = (state_next == SEND);

`ifdef OFM_RELU_EN
    assign elem_out = elem_raw[DATA_W-1] ? '0 : elem_raw;
`else
    assign elem_out = elem_raw;
`endif

    // Tile storage; contents need no reset because count tracks occupancy.
    always_ff @(posedge clk) begin
        if (capture && !(rst || clear)) begin
            tile_mem[wr_ptr_reg] <= psum_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            elem_cnt_reg <= '0;
            tile_cnt_reg <= '0;
            ofm_valid    <= 1'b0;
            ofm_data     <= '0;
            ofm_index    <= '0;
            ofm_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            elem_cnt_reg <= elem_cnt_next;
            tile_cnt_reg <= tile_cnt_next;
            ofm_valid    <= sending;
            ofm_data     <= sending ? elem_out : '0;
            ofm_index    <= sending ? 16'({tile_cnt_next, elem_cnt_next}) : 16'd0;
            ofm_last     <= sending && (tile_cnt_next == TW'(NUM_TILES - 1))
                                    && (elem_cnt_next == EW'(TILING_SIZE - 1));
            busy         <= (count_next != 2'd0) || sending;
            done         <= (state_next == DONE);
            overflow     <= overflow | (set_output & ~capture);
        end
    end
endmodule
